// File: rtl/dss_pkg.sv
// Shared types and constants for the digit-serial subtractor.
// DSS_OVF_EN (defined by the build) adds the signed-overflow output.
package dss_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DSS_WIDTH = 16;
  localparam int unsigned DSS_DIGIT = 4;

  // Digit counter width: clog2(n), never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/cla_sub_slice.sv
// Combinational DIGIT-bit subtract slice: d = x - y - bi, bo = borrow out.
// Inverted carry-look-ahead: generate = ~x & y, propagate = ~(x ^ y).
module cla_sub_slice #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   c;

  assign g = ~x & y;
  assign p = ~(x ^ y);

  // Borrow chain: a bit borrows if it generates one, or passes one through.
  always_comb begin
    c    = '0;
    c[0] = bi;
    for (int i = 0; i < int'(DIGIT); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign d  = ~p ^ c[DIGIT-1:0];
  assign bo = c[DIGIT];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Sequential a - b - bin, one DIGIT slice per clock, valid/ready on both sides.
// Optional ovf output under DSS_OVF_EN.
module digit_serial_subtractor
  import dss_pkg::*;
#(
  parameter int unsigned WIDTH = DSS_WIDTH,
  parameter int unsigned DIGIT = DSS_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef DSS_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d;
  logic             bo;
`ifdef DSS_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  cla_sub_slice #(.DIGIT(DIGIT)) u_slice (
    .x  (a_sh[DIGIT-1:0]),
    .y  (b_sh[DIGIT-1:0]),
    .bi (borrow),
    .d  (d),
    .bo (bo)
  );

  // New digit enters at the top; after N steps digit 0 sits at the bottom.
  generate
    if (N == 1) begin : g_one
      assign diff_nxt = d;
    end else begin : g_multi
      assign diff_nxt = {d, diff[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
`ifdef DSS_OVF_EN
      ovf       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= bin;
            cnt      <= '0;
`ifdef DSS_OVF_EN
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          diff   <= diff_nxt;
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            bout      <= bo;
`ifdef DSS_OVF_EN
            ovf       <= (a_msb != b_msb) && (d[DIGIT-1] != a_msb);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
